onchip_mem_arbiter: RTL
=======================

# onchip_mem_arbiter

Two-master arbiter that shares the single-port 4096x32 on-chip RAM between the Nios II data master (m0) and the VGA scan-out reader (m1). It sits between the two Avalon-MM masters and the RAM's s1 port. It does zero-cycle arbitration, with round-robin on ties and a bounded hold so that one master cannot starve the other. It tags each read so the 1-cycle RAM read data returns only to the master that issued it.

## Interface
- ADDR_W, 12, word address width (4096 words)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- HOLD_MAX, 8, maximum consecutive beats one owner keeps the grant while the other master waits (1..255)

- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- mN_address  in  ADDR_W  word address, master N (N = 0, 1)
- mN_byteenable  in  DATA_W/8  byte lanes, master N
- mN_read  in  1  read request, master N
- mN_write  in  1  write request, master N (read and write never both high)
- mN_writedata  in  DATA_W  write data, master N
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  DATA_W  read data, broadcast from mem_readdata
- mN_readdatavalid  out  1  read data valid for master N
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  DATA_W/8  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_readdata  in  DATA_W  from RAM; valid the cycle after the address is presented
- mem_clken  out  1  tied 1
- mem_reset_req  out  1  tied 0

## Operation
- reqN = mN_read | mN_write.
- State is one of IDLE, OWN0 or OWN1.
- Registers:
  - last_owner: 1 bit; reset value 1, so m0 wins the first tie.
  - hold_cnt: 8 bits; counts beats granted in the current tenure; saturates at HOLD_MAX.
  - rd_pend and rd_id: the read return tag.
- Grant is decided combinationally each cycle (g = none, 0 or 1). In the rules below, "other" is the master that is not the current owner.
  - IDLE, only one master requesting: grant that master.
  - IDLE, both requesting: grant ~last_owner.
  - OWNx: keep x if reqx & (~req_other | hold_cnt < HOLD_MAX).
  - OWNx, otherwise: grant other if req_other, else none.
- Next-state update:
  - If g is none: next state IDLE, hold_cnt <= 0.
  - If g differs from the current owner, or the state was IDLE: next state OWNg, hold_cnt <= 1, last_owner <= g.
  - If g equals the current owner: hold_cnt <= hold_cnt + 1 (saturating).
- Outputs:
  - mN_waitrequest = reqN & (g != N), forced to 1 while reset is asserted.
  - mem_* fields are muxed from master g; mem_chipselect = (g != none); mem_write = write of master g.
- Read tagging and return:
  - On each accepted read, rd_pend <= 1 and rd_id <= g; otherwise rd_pend <= 0.
  - mN_readdatavalid = rd_pend & (rd_id == N).
- Writes produce no response.
- The block never issues more than one RAM access per cycle. Back-to-back beats from either master run at full rate (one beat per cycle).

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE, hold_cnt 0, last_owner 1, rd_pend 0.
  - Both readdatavalid 0, both waitrequest 1, mem_chipselect 0, mem_write 0.
- Arbitration latency is 0: a lone request in IDLE sees waitrequest low in the same cycle.
- Read latency: a read accepted in cycle T returns mN_readdatavalid=1 in cycle T+1, with mN_readdata = mem_readdata.
- A write accepted in cycle T is committed at the clk edge that ends cycle T.
- Simultaneous requests in IDLE go to ~last_owner. A grant switches only at a beat boundary and is never split within a cycle.
- Hold limit: while the other master waits, the owner receives at most HOLD_MAX consecutive beats. The other master is then granted in the next cycle.
- A waiting master's worst-case wait is HOLD_MAX cycles.
- Back-to-back reads from alternating masters give alternating readdatavalid with no bubble.
- Reset asserted mid-read: rd_pend clears immediately and the pending readdatavalid is never issued. Any transaction in flight is dropped.
- A master that drops its request when it has no grant loses no state, and the arbiter records nothing for it.

## Test plan
- Reset then single read: m0 reads addr 0x005 with RAM word 0xDEADBEEF -> waitrequest 0 in cycle 0; m0_readdatavalid 1 with data 0xDEADBEEF in cycle 1; m1_readdatavalid stays 0.
- Tie from IDLE: m0 and m1 both read in the first cycle after reset -> m0 granted first, m1 granted next cycle; valids return at +1 for each in that order.
- Hold limit: HOLD_MAX=8, m1 streams reads 0x100..0x1FF while m0 holds one write to 0x010 -> m1 gets 8 beats, m0's write accepted in cycle 8, m1 resumes in cycle 9.
- Write/read mixing: m0 writes 0x12345678 with byteenable 0b0011 to 0x020 (prior contents 0xAAAAAAAA), then m1 reads 0x020 -> m1 receives 0xAAAA5678.
- Reset mid-read: m1 read accepted in cycle T, reset asserted during cycle T+1 -> no readdatavalid, both waitrequest 1 during reset, state IDLE after release.
- Idle owner release: m0 granted for 3 beats then deasserts read while m1 requests -> m1 granted in the same cycle, hold_cnt restarts at 1.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM.
// Zero-cycle grant, round-robin on ties, bounded hold, and read-return tagging.
module onchip_mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int HOLD_MAX = 8
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                mem_clken,
    output logic                mem_reset_req
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       last_owner_q, last_owner_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_id_q, rd_id_d;

    logic req0, req1;
    logic own_id, req_own, req_oth;
    logic gnt_vld, gnt_id;
    logic sel_read, sel_write;

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    assign own_id  = (state_q == OWN1);
    assign req_own = own_id ? req1 : req0;
    assign req_oth = own_id ? req0 : req1;

    // Grant is combinational so a lone request is accepted in the cycle it appears.
    // NOTE: every output of a combinational block gets a default first, otherwise
    // a path that skips an assignment infers a latch.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (req0 && req1) begin
                        gnt_vld = 1'b1;
                        gnt_id  = ~last_owner_q;
                    end else if (req0 || req1) begin
                        gnt_vld = 1'b1;
                        gnt_id  = req1;
                    end
                end
                OWN0, OWN1: begin
                    if (req_own && (!req_oth || hold_cnt_q < HOLD_LIM)) begin
                        gnt_vld = 1'b1;
                        gnt_id  = own_id;
                    end else if (req_oth) begin
                        gnt_vld = 1'b1;
                        gnt_id  = ~own_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sel_read  = gnt_id ? m1_read  : m0_read;
    assign sel_write = gnt_id ? m1_write : m0_write;

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        last_owner_d = last_owner_q;
        rd_pend_d    = 1'b0;
        rd_id_d      = rd_id_q;
        if (!gnt_vld) begin
            state_d    = IDLE;
            hold_cnt_d = 8'd0;
        end else if (state_q == IDLE || gnt_id != own_id) begin
            state_d      = gnt_id ? OWN1 : OWN0;
            hold_cnt_d   = 8'd1;
            last_owner_d = gnt_id;
        end else if (hold_cnt_q < HOLD_LIM) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
        if (gnt_vld && sel_read) begin
            rd_pend_d = 1'b1;
            rd_id_d   = gnt_id;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_cnt_q   <= 8'd0;
            last_owner_q <= 1'b1;
            rd_pend_q    <= 1'b0;
            rd_id_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
            rd_pend_q    <= rd_pend_d;
            rd_id_q      <= rd_id_d;
        end
    end

    assign mem_address    = gnt_id ? m1_address    : m0_address;
    assign mem_byteenable = gnt_id ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = gnt_id ? m1_writedata  : m0_writedata;
    assign mem_chipselect = gnt_vld;
    assign mem_write      = gnt_vld & sel_write;
    assign mem_clken      = 1'b1;
    assign mem_reset_req  = 1'b0;

    assign m0_waitrequest = reset | (req0 & ~(gnt_vld & ~gnt_id));
    assign m1_waitrequest = reset | (req1 & ~(gnt_vld &  gnt_id));

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pend_q & ~rd_id_q;
    assign m1_readdatavalid = rd_pend_q &  rd_id_q;

endmodule
